// File: rtl/chip8_sprite_draw_if.sv
// Command, sprite-memory and framebuffer signals of the Chip-8 sprite draw engine.
// master = the draw engine, slave = CPU / sprite memory / framebuffer side.
interface chip8_sprite_draw_if;
   logic        start;
   logic        op_clear;
   logic [7:0]  draw_x;
   logic [7:0]  draw_y;
   logic [3:0]  draw_n;
   logic [11:0] draw_i;
   logic        busy;
   logic        done;
   logic        collision;
   logic [11:0] mem_addr;
   logic [7:0]  mem_readdata;
   logic [4:0]  fb_addr_y;
   logic [5:0]  fb_addr_x;
   logic        fb_writedata;
   logic        fb_WE;
   logic        fb_readdata;

   modport master (
      input  start, op_clear, draw_x, draw_y, draw_n, draw_i, mem_readdata, fb_readdata,
      output busy, done, collision, mem_addr, fb_addr_y, fb_addr_x, fb_writedata, fb_WE
   );

   modport slave (
      output start, op_clear, draw_x, draw_y, draw_n, draw_i, mem_readdata, fb_readdata,
      input  busy, done, collision, mem_addr, fb_addr_y, fb_addr_x, fb_writedata, fb_WE
   );
endinterface

// File: rtl/chip8_sprite_draw.sv
// Chip-8 DXYN / 00E0 engine: XORs sprite rows onto the 64x32 framebuffer and reports VF.
// Optional macro SPRITE_CLIP_EN: drop off-screen sprite pixels instead of wrapping them.
module chip8_sprite_draw #(
   parameter int FB_RD_LAT  = 2,
   parameter int MEM_RD_LAT = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   chip8_sprite_draw_if.master        bus
);
   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, SCAN, RDPIX, WRPIX, DONE} state_t;

   localparam logic [1:0] MEM_LAST = 2'(MEM_RD_LAT - 1);
   localparam logic [1:0] FB_LAST  = 2'(FB_RD_LAT - 1);

   state_t      state, state_next;
   logic [5:0]  x0;
   logic [4:0]  y0;
   logic [3:0]  n;
   logic [11:0] base;
   logic [3:0]  row;
   logic [2:0]  bit_idx;
   logic [7:0]  sprite;
   logic [1:0]  wait_cnt;
   logic        old_pix;
   logic        collision;
   logic [11:0] mem_addr;
   logic [5:0]  fb_x;
   logic [4:0]  fb_y;

   logic [5:0]  pix_x;
   logic [4:0]  pix_y;
   logic        pix_on, wait_last, row_last, advance, clear_last;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pix_x      = x0 + 6'(3'd7 - bit_idx);
      pix_y      = y0 + 5'(row);
`ifdef SPRITE_CLIP_EN
      pix_on     = sprite[bit_idx]
                   && (({1'b0, x0} + 7'(3'd7 - bit_idx)) <= 7'd63)
                   && (({1'b0, y0} + 6'(row)) <= 6'd31);
`else
      pix_on     = sprite[bit_idx];
`endif
      wait_last  = (state == FETCH) ? (wait_cnt == MEM_LAST) : (wait_cnt == FB_LAST);
      row_last   = (({1'b0, row} + 5'd1) == {1'b0, n});
      advance    = ((state == SCAN) && !pix_on) || (state == WRPIX);
      clear_last = (fb_x == 6'd63) && (fb_y == 5'd31);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = bus.op_clear ? CLEAR : FETCH;
         CLEAR:   if (clear_last) state_next = DONE;
         FETCH:   if (n == 4'd0)    state_next = DONE;
                  else if (wait_last) state_next = SCAN;
         SCAN:    if (pix_on)            state_next = RDPIX;
                  else if (bit_idx == 3'd0) state_next = row_last ? DONE : FETCH;
         RDPIX:   if (wait_last) state_next = WRPIX;
         WRPIX:   if (bit_idx == 3'd0) state_next = row_last ? DONE : FETCH;
                  else                 state_next = SCAN;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy         = (state != IDLE) && (state != DONE);
      bus.done         = (state == DONE);
      bus.fb_WE        = (state == CLEAR) || (state == WRPIX);
      bus.fb_writedata = (state == WRPIX) && !old_pix;
      bus.collision    = collision;
      bus.mem_addr     = mem_addr;
      bus.fb_addr_x    = fb_x;
      bus.fb_addr_y    = fb_y;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x0 <= '0; y0 <= '0; n <= '0; base <= '0;
         row <= '0; bit_idx <= 3'd7; sprite <= '0; wait_cnt <= '0;
         old_pix <= 1'b0; collision <= 1'b0;
         mem_addr <= '0; fb_x <= '0; fb_y <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               x0        <= bus.draw_x[5:0];
               y0        <= bus.draw_y[4:0];
               n         <= bus.draw_n;
               base      <= bus.draw_i;
               mem_addr  <= bus.draw_i;
               row       <= '0;
               bit_idx   <= 3'd7;
               wait_cnt  <= '0;
               collision <= 1'b0;
               if (bus.op_clear) begin
                  fb_x <= '0;
                  fb_y <= '0;
               end
            end
            CLEAR: begin
               fb_x <= fb_x + 6'd1;
               if (fb_x == 6'd63) fb_y <= fb_y + 5'd1;
            end
            FETCH: if (n != 4'd0) begin
               if (wait_last) begin
                  sprite   <= bus.mem_readdata;
                  bit_idx  <= 3'd7;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            SCAN: if (pix_on) begin
               // Address is frozen here and held through the read and write of this pixel.
               fb_x     <= pix_x;
               fb_y     <= pix_y;
               wait_cnt <= '0;
            end
            RDPIX: begin
               if (wait_last) begin
                  old_pix  <= bus.fb_readdata;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            WRPIX: if (old_pix) collision <= 1'b1;
            default: ;
         endcase

         if (advance) begin
            if (bit_idx == 3'd0) begin
               row      <= row + 4'd1;
               mem_addr <= base + 12'(row) + 12'd1;
               wait_cnt <= '0;
            end else begin
               bit_idx  <= bit_idx - 3'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Self-checking bench for chip8_sprite_draw: behavioural framebuffer model, per-cycle compare.
// Build with +define+SPRITE_CLIP_EN to check the clipping variant.
`timescale 1ns/1ps
module tb_chip8_sprite_draw;
   localparam int FB_RD_LAT  = 2;
   localparam int MEM_RD_LAT = 1;

   typedef struct {int x; int y; int d;} wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   chip8_sprite_draw_if bus();

   chip8_sprite_draw #(.FB_RD_LAT(FB_RD_LAT), .MEM_RD_LAT(MEM_RD_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Sprite memory and framebuffer models with configurable read latency
   logic [7:0]  mem [4096];
   bit          fb [32][64];
   bit          ref_fb [32][64];
   logic [11:0] mem_q [4];
   logic [10:0] fb_q [4];
   logic [11:0] mem_sel;
   logic [10:0] fb_sel;

   always @(posedge clk) begin
      mem_q[0] <= bus.mem_addr;
      fb_q[0]  <= {bus.fb_addr_y, bus.fb_addr_x};
      for (int k = 1; k < 4; k++) begin
         mem_q[k] <= mem_q[k-1];
         fb_q[k]  <= fb_q[k-1];
      end
      if (bus.fb_WE) fb[bus.fb_addr_y][bus.fb_addr_x] <= bus.fb_writedata;
   end

   always_comb begin
      mem_sel = (MEM_RD_LAT > 1) ? mem_q[(MEM_RD_LAT > 1) ? MEM_RD_LAT - 2 : 0] : bus.mem_addr;
      fb_sel  = (FB_RD_LAT > 1)  ? fb_q[(FB_RD_LAT > 1) ? FB_RD_LAT - 2 : 0]
                                 : {bus.fb_addr_y, bus.fb_addr_x};
   end
   assign bus.mem_readdata = mem[mem_sel];
   assign bus.fb_readdata  = fb[fb_sel[10:6]][fb_sel[5:0]];

   int  n_cmp = 0, n_fail = 0;
   wr_t exp_wr[$];
   int  exp_cost, rel, busy_cnt, done_rel;
   bit  exp_coll, cmd_active = 1'b0, last_coll;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int count_ones();
      int c = 0;
      for (int yy = 0; yy < 32; yy++)
         for (int xx = 0; xx < 64; xx++) c += int'(fb[yy][xx]);
      return c;
   endfunction

   function automatic int fb_diffs();
      int c = 0;
      for (int yy = 0; yy < 32; yy++)
         for (int xx = 0; xx < 64; xx++) c += int'(fb[yy][xx] != ref_fb[yy][xx]);
      return c;
   endfunction

   // Reference: Chip-8 semantics on a plain pixel array, plus the cycle-cost rule
   task automatic model(input bit op, input int x, input int y, input int n, input int i);
      int       x0, y0, px, py;
      bit       on;
      bit [7:0] sb;
      x0 = x % 64;
      y0 = y % 32;
      exp_wr.delete();
      exp_coll = 1'b0;
      if (op) begin
         exp_cost = 2048;
         for (int yy = 0; yy < 32; yy++)
            for (int xx = 0; xx < 64; xx++) begin
               exp_wr.push_back('{xx, yy, 0});
               ref_fb[yy][xx] = 1'b0;
            end
      end else begin
         exp_cost = (n == 0) ? 1 : 0;
         for (int r = 0; r < n; r++) begin
            sb = mem[(i + r) % 4096];
            exp_cost += MEM_RD_LAT;
            for (int c = 0; c < 8; c++) begin
               px = x0 + c;
               py = y0 + r;
               on = sb[7 - c];
`ifdef SPRITE_CLIP_EN
               if (px > 63 || py > 31) on = 1'b0;
`endif
               px = px % 64;
               py = py % 32;
               if (on) begin
                  exp_cost += 2 + FB_RD_LAT;
                  if (ref_fb[py][px]) exp_coll = 1'b1;
                  ref_fb[py][px] = !ref_fb[py][px];
                  exp_wr.push_back('{px, py, int'(ref_fb[py][px])});
               end else begin
                  exp_cost += 1;
               end
            end
         end
      end
   endtask

   // Per-cycle compare of handshake, write stream and collision against the model
   always @(negedge clk) begin
      wr_t w;
      if (cmd_active) begin
         rel++;
         check("busy", bus.busy, 32'(rel >= 1 && rel <= exp_cost));
         check("done", bus.done, 32'(rel == exp_cost + 1));
         if (bus.busy) busy_cnt++;
         if (bus.done) done_rel = rel;
         if (bus.fb_WE) begin
            if (exp_wr.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL extra_write: write at (%0d,%0d) with none expected", bus.fb_addr_x, bus.fb_addr_y);
            end else begin
               w = exp_wr.pop_front();
               check("wr_x", bus.fb_addr_x, w.x);
               check("wr_y", bus.fb_addr_y, w.y);
               check("wr_data", bus.fb_writedata, w.d);
            end
         end
         if (rel == exp_cost + 1) begin
            check("collision", bus.collision, exp_coll);
            check("writes_left", exp_wr.size(), 0);
            last_coll  = bus.collision;
            cmd_active = 1'b0;
         end
      end else if (reset) begin
         check("idle_we", bus.fb_WE, 0);
      end
   end

   task automatic issue(input bit op, input int x, input int y, input int n, input int i, input int extra);
      model(op, x, y, n, i);
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.op_clear = op;
      bus.draw_x   = 8'(x);
      bus.draw_y   = 8'(y);
      bus.draw_n   = 4'(n);
      bus.draw_i   = 12'(i);
      busy_cnt     = 0;
      done_rel     = -1;
      rel          = -1;
      cmd_active   = 1'b1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.draw_x = 8'($urandom);
      bus.draw_y = 8'($urandom);
      bus.draw_n = 4'($urandom);
      bus.draw_i = 12'($urandom);
      if (extra > 0) begin
         repeat (extra) @(posedge clk);
         #1;
         bus.start    = 1'b1;
         bus.op_clear = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      for (int k = 0; k < exp_cost + 20 && cmd_active; k++) @(negedge clk);
      if (cmd_active) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: command did not finish in %0d cycles", exp_cost + 20);
         cmd_active = 1'b0;
      end
      check("fb_image_diffs", fb_diffs(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int x, y, n, i;
      bus.start = 1'b0; bus.op_clear = 1'b0;
      bus.draw_x = '0; bus.draw_y = '0; bus.draw_n = '0; bus.draw_i = '0;
      for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
      for (int yy = 0; yy < 32; yy++)
         for (int xx = 0; xx < 64; xx++) begin
            fb[yy][xx]     = 1'b1;
            ref_fb[yy][xx] = 1'b1;
         end

      #12;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_collision", bus.collision, 0);
      check("rst_fb_we", bus.fb_WE, 0);
      check("rst_fb_wdata", bus.fb_writedata, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_fb_x", bus.fb_addr_x, 0);
      check("rst_fb_y", bus.fb_addr_y, 0);
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);

      // Clear on an all-ones screen
      issue(1'b1, 0, 0, 0, 0, 0);
      check("clear_ones", count_ones(), 0);
      check("clear_busy_cycles", busy_cnt, 2048);
      check("clear_collision", last_coll, 0);

      // Single pixel, then redraw to erase with collision
      mem[12'h200] = 8'h80;
      issue(1'b0, 1, 1, 1, 'h200, 0);
      check("basic_px_1_1", fb[1][1], 1);
      check("basic_count", count_ones(), 1);
      check("basic_coll", last_coll, 0);
      check("basic_cycles", busy_cnt, 12);
      issue(1'b0, 1, 1, 1, 'h200, 0);
      check("redraw_px_1_1", fb[1][1], 0);
      check("redraw_count", count_ones(), 0);
      check("redraw_coll", last_coll, 1);

      // Multi-row draw with a stray start pulse while busy
      mem[12'h300] = 8'hF0; mem[12'h301] = 8'h90; mem[12'h302] = 8'hF0;
      issue(1'b0, 10, 5, 3, 'h300, 5);
      check("multi_count", count_ones(), 10);
      check("multi_px_10_5", fb[5][10], 1);
      check("multi_px_13_5", fb[5][13], 1);
      check("multi_px_11_6", fb[6][11], 0);
      check("multi_px_13_6", fb[6][13], 1);
      check("multi_px_12_7", fb[7][12], 1);
      check("multi_cycles", busy_cnt, 57);
      check("multi_coll", last_coll, 0);

      // Edge wrap / clip
      issue(1'b1, 0, 0, 0, 0, 0);
      mem[12'h400] = 8'hFF; mem[12'h401] = 8'hFF;
      issue(1'b0, 60, 31, 2, 'h400, 0);
`ifdef SPRITE_CLIP_EN
      check("edge_count", count_ones(), 4);
      check("edge_px_60_31", fb[31][60], 1);
      check("edge_px_0_0", fb[0][0], 0);
`else
      check("edge_count", count_ones(), 16);
      check("edge_px_63_31", fb[31][63], 1);
      check("edge_px_0_0", fb[0][0], 1);
      check("edge_px_3_0", fb[0][3], 1);
`endif

      // Zero-height sprite
      issue(1'b0, 3, 3, 0, 'h123, 0);
      check("n0_done_latency", done_rel, 2);
      check("n0_coll", last_coll, 0);

      // Reset during RDPIX of a fresh draw
      mem[12'h500] = 8'h80;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op_clear = 1'b0;
      bus.draw_x = 8'd20; bus.draw_y = 8'd10; bus.draw_n = 4'd1; bus.draw_i = 12'h500;
      @(posedge clk); #1; bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_busy", bus.busy, 1);
      check("pre_rst_fb_x", bus.fb_addr_x, 20);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_fb_we", bus.fb_WE, 0);
      check("mid_rst_collision", bus.collision, 0);
      check("mid_rst_mem_addr", bus.mem_addr, 0);
      check("mid_rst_fb_x", bus.fb_addr_x, 0);
      check("mid_rst_fb_y", bus.fb_addr_y, 0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      check("mid_rst_fb_image", fb_diffs(), 0);
      issue(1'b0, 20, 10, 1, 'h500, 0);
      check("post_rst_px_20_10", fb[10][20], 1);

      // Randomized commands against the model
      for (int t = 0; t < 24; t++) begin
         x = $urandom_range(0, 255);
         y = $urandom_range(0, 255);
         n = $urandom_range(0, 15);
         i = $urandom_range(0, 4095);
         for (int r = 0; r < n; r++) mem[(i + r) % 4096] = 8'($urandom);
         if (t == 12) issue(1'b1, 0, 0, 0, 0, 0);
         else         issue(1'b0, x, y, n, i, (n > 2) ? int'($urandom_range(0, 3)) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
